// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and FSM state encoding
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int UART_CLKS_PER_BIT = 104;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_e;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter pulsing tick after a full or half bit period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic half,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Count up, wrapping to 0 on the terminal value or when held clear
    always_comb begin
        tick  = !clear && cnt_q == (half ? HALF_LAST : FULL_LAST);
        cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
    end
    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_phy.sv
// uart_phy: 8N1 UART transceiver with independent TX and RX state machines
module uart_phy import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_frame_err
);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    state_e     tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [2:0] tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic       tx_q, tx_d, tx_rdy_q, tx_rdy_d, rx_rdy_q, rx_rdy_d, rx_err_q, rx_err_d;
    logic       rx_m_q, rx_s_q, tx_tick, rx_tick;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk(clk), .rst(rst), .clear(tx_st_q == ST_IDLE), .half(1'b0), .tick(tx_tick)
    );
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk(clk), .rst(rst), .clear(rx_st_q == ST_IDLE || rx_st_q == ST_BREAK),
        .half(rx_st_q == ST_START), .tick(rx_tick)
    );

    // TX next state: outputs are computed from the next state so they come out registered
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_sh_d  = tx_sh_q;
        tx_idx_d = tx_idx_q;
        tx_d     = tx_q;
        tx_rdy_d = tx_rdy_q;
        case (tx_st_q)
            ST_IDLE: if (tx_en) begin
                tx_st_d  = ST_START;
                tx_sh_d  = tx_data;
                tx_idx_d = '0;
                tx_d     = 1'b0;
                tx_rdy_d = 1'b0;
            end
            ST_START: if (tx_tick) begin
                tx_st_d = ST_DATA;
                tx_d    = tx_sh_q[0];
            end
            ST_DATA: if (tx_tick) begin
                if (tx_idx_q == LAST_BIT) begin
                    tx_st_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_d     = tx_sh_q[1];
                    tx_idx_d = tx_idx_q + 1'b1;
                end
            end
            ST_STOP: if (tx_tick) begin
                tx_st_d  = ST_IDLE;
                tx_rdy_d = 1'b1;
            end
            default: begin
                tx_st_d  = ST_IDLE;
                tx_d     = 1'b1;
                tx_rdy_d = 1'b1;
            end
        endcase
    end

    // RX next state: START samples at half a bit, later samples land mid-bit
    always_comb begin
        rx_st_d   = rx_st_q;
        rx_sh_d   = rx_sh_q;
        rx_idx_d  = rx_idx_q;
        rx_data_d = rx_data_q;
        rx_rdy_d  = 1'b0;
        rx_err_d  = 1'b0;
        case (rx_st_q)
            ST_IDLE: rx_st_d = rx_s_q ? ST_IDLE : ST_START;
            ST_START: if (rx_tick) begin
                rx_st_d  = rx_s_q ? ST_IDLE : ST_DATA;
                rx_idx_d = '0;
            end
            ST_DATA: if (rx_tick) begin
                rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
                rx_idx_d = rx_idx_q + 1'b1;
                rx_st_d  = rx_idx_q == LAST_BIT ? ST_STOP : ST_DATA;
            end
            ST_STOP: if (rx_tick) begin
                rx_st_d   = rx_s_q ? ST_IDLE : ST_BREAK;
                rx_data_d = rx_s_q ? rx_sh_q : rx_data_q;
                rx_rdy_d  = rx_s_q;
                rx_err_d  = !rx_s_q;
            end
            ST_BREAK: rx_st_d = rx_s_q ? ST_IDLE : ST_BREAK;
            default:  rx_st_d = ST_IDLE;
        endcase
    end

    // State registers and the two-flop rx synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st_q   <= ST_IDLE;
            tx_sh_q   <= '0;
            tx_idx_q  <= '0;
            tx_q      <= 1'b1;
            tx_rdy_q  <= 1'b1;
            rx_m_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_st_q   <= ST_IDLE;
            rx_sh_q   <= '0;
            rx_idx_q  <= '0;
            rx_data_q <= '0;
            rx_rdy_q  <= 1'b0;
            rx_err_q  <= 1'b0;
        end else begin
            tx_st_q   <= tx_st_d;
            tx_sh_q   <= tx_sh_d;
            tx_idx_q  <= tx_idx_d;
            tx_q      <= tx_d;
            tx_rdy_q  <= tx_rdy_d;
            rx_m_q    <= rx;
            rx_s_q    <= rx_m_q;
            rx_st_q   <= rx_st_d;
            rx_sh_q   <= rx_sh_d;
            rx_idx_q  <= rx_idx_d;
            rx_data_q <= rx_data_d;
            rx_rdy_q  <= rx_rdy_d;
            rx_err_q  <= rx_err_d;
        end
    end

    assign tx           = tx_q;
    assign tx_ready     = tx_rdy_q;
    assign rx_ready     = rx_rdy_q;
    assign rx_data      = rx_data_q;
    assign rx_frame_err = rx_err_q;
endmodule

// File: tb/tb_uart_phy.sv
// tb_uart_phy: self-checking bench for the 8N1 UART transceiver
module tb_uart_phy;
    localparam int CPB = 16;
    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         gap;
        int         idle;
        int         exp_rdy;
        int         exp_err;
        logic [7:0] exp_data;
    } rxv_t;

    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, tx_en = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx, tx_ready, rx_ready, rx_frame_err;
    logic [7:0] rx_data;
    int         checks = 0, errors = 0;
    int         n_rdy = 0, n_err = 0, n_both = 0, n_fall = 0;
    logic       prev_rdy = 1'b1;
    logic [7:0] model_data;
    rxv_t       tbl [4];

    uart_phy #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .tx_en(tx_en), .tx_data(tx_data),
        .tx_ready(tx_ready), .rx_ready(rx_ready), .rx_data(rx_data), .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_ready === 1'b1) n_rdy++;
        if (rx_frame_err === 1'b1) n_err++;
        if (rx_ready === 1'b1 && rx_frame_err === 1'b1) n_both++;
        if (prev_rdy === 1'b1 && tx_ready === 1'b0) n_fall++;
        prev_rdy = tx_ready;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Send one byte and check every cycle of the serial frame against {stop, data, start}
    task automatic send_tx(input logic [7:0] d, input bit extra);
        int t = 0;
        int f0;
        logic [9:0] frame = {1'b1, d, 1'b0};
        logic [9:0] bad = '0;
        logic rdy_bad = 1'b0;
        while (tx_ready !== 1'b1 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("tx_ready_idle", tx_ready, 1);
        f0 = n_fall;
        tx_data = d;
        tx_en = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 10 * CPB; k++) begin
            tx_en = extra && (k == 4 || k == 39);
            tx_data = ~d;
            if (tx !== frame[k / CPB]) bad[k / CPB] = 1'b1;
            if (tx_ready !== 1'b0) rdy_bad = 1'b1;
            @(posedge clk); #1;
        end
        tx_en = 1'b0;
        for (int b = 0; b < 10; b++) chk($sformatf("tx_%02h_bit%0d_wrong", d, b), bad[b], 0);
        chk("tx_ready_busy_high", rdy_bad, 0);
        chk("tx_ready_at_160", tx_ready, 1);
        chk("tx_ready_fall_count", n_fall - f0, 1);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx_chk(input string name, input logic [7:0] d, input logic stop, input int gap,
                               input int exp_rdy, input int exp_err, input logic [7:0] exp_data);
        int r0 = n_rdy;
        int e0 = n_err;
        send_rx(d, stop);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        chk({name, "_rx_ready_pulses"}, n_rdy - r0, exp_rdy);
        chk({name, "_rx_err_pulses"}, n_err - e0, exp_err);
        chk({name, "_rx_data"}, rx_data, exp_data);
    endtask

    initial begin
        int r0, e0;
        logic [7:0] d_tx, d_rx;
        logic stop;
        tbl[0] = '{8'h3C, 1'b1, 0, 0, 1, 0, 8'h3C};
        tbl[1] = '{8'hFF, 1'b1, 0, 5, 1, 0, 8'hFF};
        tbl[2] = '{8'h55, 1'b0, 100, 20, 0, 1, 8'hFF};
        tbl[3] = '{8'hA7, 1'b1, 0, 5, 1, 0, 8'hA7};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_frame_err", rx_frame_err, 0);
        rst = 1'b0;
        model_data = 8'h00;
        @(posedge clk); #1;

        send_tx(8'hA5, 1'b0);

        foreach (tbl[i]) begin
            send_rx_chk($sformatf("tbl%0d", i), tbl[i].d, tbl[i].stop, tbl[i].gap,
                        tbl[i].exp_rdy, tbl[i].exp_err, tbl[i].exp_data);
            rx = 1'b1;
            model_data = tbl[i].exp_data;
            if (tbl[i].idle > 0) begin
                repeat (tbl[i].idle) @(posedge clk);
                #1;
            end
        end

        r0 = n_rdy;
        e0 = n_err;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        chk("glitch_rx_ready", n_rdy - r0, 0);
        chk("glitch_rx_err", n_err - e0, 0);
        chk("glitch_rx_data", rx_data, model_data);

        fork
            send_tx(8'h12, 1'b1);
            send_rx_chk("duplex81", 8'h81, 1'b1, 0, 1, 0, 8'h81);
        join
        model_data = 8'h81;
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            d_tx = 8'($urandom);
            d_rx = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            fork
                send_tx(d_tx, 1'b0);
                send_rx_chk($sformatf("rnd%0d", i), d_rx, stop, 0, stop ? 1 : 0, stop ? 0 : 1,
                            stop ? d_rx : model_data);
            join
            if (stop) model_data = d_rx;
            rx = 1'b1;
            repeat (10) @(posedge clk);
            #1;
        end

        tx_data = 8'h99;
        tx_en = 1'b1;
        @(posedge clk); #1;
        tx_en = 1'b0;
        rx = 1'b0;
        r0 = n_rdy;
        repeat (69) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_tx_ready", tx_ready, 1);
        chk("async_rst_rx_data", rx_data, 0);
        rx = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        chk("post_rst_no_rx_ready", n_rdy - r0, 0);
        chk("post_rst_tx_idle", tx, 1);
        send_rx_chk("after_rst7E", 8'h7E, 1'b1, 0, 1, 0, 8'h7E);
        chk("ready_and_err_never_together", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
